exhaustive_stim_capture: RTL and testbench

- Hardware stimulus/response stage wrapped around a small combinational or sequential benchmark DUT in the trojan-detection flow.
- Drives every N_IN-bit input vector 0..2^N_IN-1 into the DUT in ascending order.
- After a programmable settle time, samples the DUT's single-bit output for each vector.
- Produces a per-vector response strobe, a packed response vector, and a serial CRC signature, so golden and suspect DUTs can be compared without file I/O.

---
 rtl/exhaustive_stim_capture.sv | 131 +++++++++++++
 tb/tb_exhaustive_stim_capture.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exhaustive_stim_capture.sv
// rtl/exhaustive_stim_capture.sv - exhaustive vector driver with per-vector response capture and CRC signature
module exhaustive_stim_capture #(
  parameter int                N_IN   = 3,
  parameter int                SETTLE = 1,
  parameter int                SIG_W  = 16,
  parameter logic [SIG_W-1:0]  POLY   = 16'h1021,
  parameter logic [SIG_W-1:0]  SEED   = 16'hFFFF
) (
  input  logic                    CK,
  input  logic                    reset,
  input  logic                    start,
  output logic [N_IN-1:0]         pattern,
  output logic                    pattern_valid,
  input  logic                    dut_out,
  output logic                    resp_valid,
  output logic                    resp_bit,
  output logic [N_IN-1:0]         resp_index,
  output logic                    busy,
  output logic                    done,
  output logic [(1<<N_IN)-1:0]    response_vec,
  output logic [SIG_W-1:0]        signature
);

  localparam logic [N_IN-1:0] LAST_PAT = {N_IN{1'b1}};
  localparam logic [3:0]      SETTLE_C = 4'(SETTLE);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [N_IN-1:0]         pattern_q, pattern_d;
  logic                    pattern_valid_q, pattern_valid_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_bit_q, resp_bit_d;
  logic [N_IN-1:0]         resp_index_q, resp_index_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [(1<<N_IN)-1:0]    response_vec_q, response_vec_d;
  logic [SIG_W-1:0]        signature_q, signature_d;
  logic [3:0]              settle_cnt_q, settle_cnt_d;
  logic                    fb;

  always_comb begin
    state_d         = state_q;
    pattern_d       = pattern_q;
    pattern_valid_d = pattern_valid_q;
    resp_valid_d    = 1'b0;
    resp_bit_d      = resp_bit_q;
    resp_index_d    = resp_index_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    response_vec_d  = response_vec_q;
    signature_d     = signature_q;
    settle_cnt_d    = settle_cnt_q;
    fb              = signature_q[SIG_W-1] ^ dut_out;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d         = ST_RUN;
          busy_d          = 1'b1;
          pattern_d       = '0;
          pattern_valid_d = 1'b1;
          settle_cnt_d    = 4'd0;
          response_vec_d  = '0;
          signature_d     = SEED;
        end
      end
      ST_RUN: begin
        if (settle_cnt_q < SETTLE_C) begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end else begin
          // Sample edge: capture, strobe, and fold the bit into the CRC
          response_vec_d[pattern_q] = dut_out;
          resp_bit_d   = dut_out;
          resp_index_d = pattern_q;
          resp_valid_d = 1'b1;
          signature_d  = {signature_q[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
          if (pattern_q != LAST_PAT) begin
            pattern_d    = pattern_q + 1'b1;
            settle_cnt_d = 4'd0;
          end else begin
            state_d         = ST_IDLE;
            busy_d          = 1'b0;
            pattern_valid_d = 1'b0;
            done_d          = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      pattern_q       <= '0;
      pattern_valid_q <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_bit_q      <= 1'b0;
      resp_index_q    <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      response_vec_q  <= '0;
      signature_q     <= '0;
      settle_cnt_q    <= 4'd0;
    end else begin
      state_q         <= state_d;
      pattern_q       <= pattern_d;
      pattern_valid_q <= pattern_valid_d;
      resp_valid_q    <= resp_valid_d;
      resp_bit_q      <= resp_bit_d;
      resp_index_q    <= resp_index_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      response_vec_q  <= response_vec_d;
      signature_q     <= signature_d;
      settle_cnt_q    <= settle_cnt_d;
    end
  end

  assign pattern       = pattern_q;
  assign pattern_valid = pattern_valid_q;
  assign resp_valid    = resp_valid_q;
  assign resp_bit      = resp_bit_q;
  assign resp_index    = resp_index_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign response_vec  = response_vec_q;
  assign signature     = signature_q;

endmodule

// File: tb/tb_exhaustive_stim_capture.sv
// tb/tb_exhaustive_stim_capture.sv - scoreboard bench for exhaustive_stim_capture
module tb_exhaustive_stim_capture;

  localparam logic [7:0] PARITY_TT = 8'h96;

  typedef struct packed {
    logic [2:0] idx;
    logic       bit_v;
  } exp_t;

  logic        CK = 1'b0;
  logic        reset;
  logic        start_s [2];
  int          mode_s  [2];
  logic        dut_out0, dut_out1;
  logic        reg0, reg1;

  logic [2:0]  pattern_w       [2];
  logic        pattern_valid_w [2];
  logic        resp_valid_w    [2];
  logic        resp_bit_w      [2];
  logic [2:0]  resp_index_w    [2];
  logic        busy_w          [2];
  logic        done_w          [2];
  logic [7:0]  response_vec_w  [2];
  logic [15:0] signature_w     [2];

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 CK = ~CK;

  exhaustive_stim_capture #(.N_IN(3), .SETTLE(1), .SIG_W(16), .POLY(16'h1021), .SEED(16'hFFFF)) dut_a (
    .CK(CK), .reset(reset), .start(start_s[0]),
    .pattern(pattern_w[0]), .pattern_valid(pattern_valid_w[0]), .dut_out(dut_out0),
    .resp_valid(resp_valid_w[0]), .resp_bit(resp_bit_w[0]), .resp_index(resp_index_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .response_vec(response_vec_w[0]), .signature(signature_w[0])
  );

  exhaustive_stim_capture #(.N_IN(3), .SETTLE(0), .SIG_W(16), .POLY(16'h1021), .SEED(16'h0000)) dut_b (
    .CK(CK), .reset(reset), .start(start_s[1]),
    .pattern(pattern_w[1]), .pattern_valid(pattern_valid_w[1]), .dut_out(dut_out1),
    .resp_valid(resp_valid_w[1]), .resp_bit(resp_bit_w[1]), .resp_index(resp_index_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .response_vec(response_vec_w[1]), .signature(signature_w[1])
  );

  // Benchmark DUTs: mode 0 = AND3, 1 = tied low, 2 = registered 3-input parity
  always @(posedge CK) begin
    reg0 <= PARITY_TT[pattern_w[0]];
    reg1 <= PARITY_TT[pattern_w[1]];
  end

  always_comb begin
    case (mode_s[0])
      0:       dut_out0 = &pattern_w[0];
      1:       dut_out0 = 1'b0;
      default: dut_out0 = reg0;
    endcase
    case (mode_s[1])
      0:       dut_out1 = &pattern_w[1];
      1:       dut_out1 = 1'b0;
      default: dut_out1 = reg1;
    endcase
  end

  function automatic logic model_resp(input int mode, input int v, input logic [2:0] prev, input int per_vec);
    logic [7:0] tt;
    case (mode)
      0:       tt = 8'h80;
      1:       tt = 8'h00;
      default: tt = PARITY_TT;
    endcase
    // A registered DUT with no settle time lags one vector behind
    if (mode == 2 && per_vec == 1) return (v == 0) ? tt[prev] : tt[3'(v - 1)];
    return tt[3'(v)];
  endfunction

  function automatic logic [15:0] crc_model(input logic [15:0] seed, input logic [7:0] resp);
    logic [15:0] s;
    s = seed;
    for (int i = 0; i < 8; i++) begin
      if (s[15] ^ resp[i]) s = {s[14:0], 1'b0} ^ 16'h1021;
      else                 s = {s[14:0], 1'b0};
    end
    return s;
  endfunction

  task automatic run_check(input string name, input int which, input int mode,
                           input logic [2:0] prev, input bit repulse, input bit abort);
    int          per_vec  = (which == 0) ? 2 : 1;
    logic [15:0] seed     = (which == 0) ? 16'hFFFF : 16'h0000;
    logic [7:0]  exp_vec;
    int          done_cnt = 0;
    int          resp_cnt = 0;
    int          exp_pat;
    exp_t        e;

    mode_s[which] = mode;
    sb_q.delete();
    for (int v = 0; v < 8; v++) begin
      e.idx   = 3'(v);
      e.bit_v = model_resp(mode, v, prev, per_vec);
      exp_vec[v] = e.bit_v;
      sb_q.push_back(e);
    end

    @(negedge CK);
    start_s[which] = 1'b1;
    @(posedge CK);
    #1;
    start_s[which] = 1'b0;
    n_checks++;
    if ({busy_w[which], pattern_w[which], pattern_valid_w[which]} !== 5'b1_000_1) begin
      n_fail++;
      $display("FAIL %s accept: busy=%b pattern=%0d pattern_valid=%b required 1/0/1",
               name, busy_w[which], pattern_w[which], pattern_valid_w[which]);
    end
    n_checks++;
    if (signature_w[which] !== seed) begin
      n_fail++;
      $display("FAIL %s seed: signature=%h required %h", name, signature_w[which], seed);
    end

    for (int c = 1; c <= 8 * per_vec + 4; c++) begin
      @(posedge CK);
      #1;
      if (repulse) start_s[which] = (c == 4 * per_vec);
      exp_pat = (c < 8 * per_vec) ? c / per_vec : 7;
      n_checks++;
      if (pattern_w[which] !== 3'(exp_pat)) begin
        n_fail++;
        $display("FAIL %s pattern c=%0d: pattern=%0d required %0d", name, c, pattern_w[which], exp_pat);
      end
      if (resp_valid_w[which]) begin
        resp_cnt++;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra strobe c=%0d: index=%0d required no strobe", name, c, resp_index_w[which]);
        end else begin
          e = sb_q.pop_front();
          if (resp_index_w[which] !== e.idx || resp_bit_w[which] !== e.bit_v) begin
            n_fail++;
            $display("FAIL %s resp: index=%0d bit=%b required index=%0d bit=%b",
                     name, resp_index_w[which], resp_bit_w[which], e.idx, e.bit_v);
          end
          n_checks++;
          if (c != (int'(e.idx) + 1) * per_vec) begin
            n_fail++;
            $display("FAIL %s resp timing idx=%0d: cycle=%0d required %0d",
                     name, e.idx, c, (int'(e.idx) + 1) * per_vec);
          end
        end
      end
      if (done_w[which]) begin
        done_cnt++;
        n_checks++;
        if (c != 8 * per_vec) begin
          n_fail++;
          $display("FAIL %s done timing: cycle=%0d required %0d", name, c, 8 * per_vec);
        end
      end
      if (abort && c == 4 * per_vec) begin
        reset = 1'b1;
        @(posedge CK);
        @(posedge CK);
        #1;
        n_checks++;
        if ({pattern_w[which], pattern_valid_w[which], resp_valid_w[which], resp_bit_w[which],
             resp_index_w[which], busy_w[which], done_w[which], response_vec_w[which],
             signature_w[which]} !== 35'd0) begin
          n_fail++;
          $display("FAIL %s abort clear: pattern=%0d busy=%b done=%b vec=%h sig=%h required all 0",
                   name, pattern_w[which], busy_w[which], done_w[which],
                   response_vec_w[which], signature_w[which]);
        end
        reset = 1'b0;
        for (int k = 0; k < 6 * per_vec; k++) begin
          @(posedge CK);
          #1;
          if (done_w[which] || resp_valid_w[which] || busy_w[which]) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s post-abort activity: done=%b resp_valid=%b busy=%b required 0",
                     name, done_w[which], resp_valid_w[which], busy_w[which]);
          end
        end
        n_checks++;
        if (done_cnt != 0) begin
          n_fail++;
          $display("FAIL %s abort done count: %0d required 0", name, done_cnt);
        end
        sb_q.delete();
        return;
      end
    end

    n_checks++;
    if (done_cnt != 1 || resp_cnt != 8 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s counts: done=%0d strobes=%0d pending=%0d required 1/8/0",
               name, done_cnt, resp_cnt, sb_q.size());
    end
    n_checks++;
    if (response_vec_w[which] !== exp_vec) begin
      n_fail++;
      $display("FAIL %s response_vec: %h required %h", name, response_vec_w[which], exp_vec);
    end
    n_checks++;
    if (signature_w[which] !== crc_model(seed, exp_vec)) begin
      n_fail++;
      $display("FAIL %s signature: %h required %h", name, signature_w[which], crc_model(seed, exp_vec));
    end
    n_checks++;
    if (busy_w[which] !== 1'b0 || pattern_valid_w[which] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle after run: busy=%b pattern_valid=%b required 0/0",
               name, busy_w[which], pattern_valid_w[which]);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    start_s[0] = 1'b1;
    start_s[1] = 1'b1;
    repeat (2) @(posedge CK);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({pattern_w[i], pattern_valid_w[i], resp_valid_w[i], resp_bit_w[i], resp_index_w[i],
           busy_w[i], done_w[i], response_vec_w[i], signature_w[i]} !== 35'd0) begin
        n_fail++;
        $display("FAIL reset inst%0d: pattern=%0d busy=%b done=%b vec=%h sig=%h required all 0",
                 i, pattern_w[i], busy_w[i], done_w[i], response_vec_w[i], signature_w[i]);
      end
    end
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    reset      = 1'b0;
    @(posedge CK);
    #1;
  endtask

  task automatic test_and3();
    run_check("and3", 0, 0, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if (response_vec_w[0] !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL and3 truth table: %b required 10000000", response_vec_w[0]);
    end
  endtask

  task automatic test_zero_seed_ffff();
    run_check("zero_ffff", 0, 1, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if (response_vec_w[0] !== 8'h00 || signature_w[0] !== 16'hE1F0) begin
      n_fail++;
      $display("FAIL zero_ffff golden: vec=%h sig=%h required 00/e1f0", response_vec_w[0], signature_w[0]);
    end
  endtask

  task automatic test_zero_seed_0000();
    run_check("zero_0000", 1, 1, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if (signature_w[1] !== 16'h0000) begin
      n_fail++;
      $display("FAIL zero_0000 golden: sig=%h required 0000", signature_w[1]);
    end
  endtask

  task automatic test_restart_ignored();
    run_check("restart_ignored", 0, 0, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_abort();
    run_check("abort", 0, 0, 3'd0, 1'b0, 1'b1);
    run_check("after_abort_reg_settle1", 0, 2, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if (response_vec_w[0] !== PARITY_TT) begin
      n_fail++;
      $display("FAIL reg_settle1 truth table: %h required %h", response_vec_w[0], PARITY_TT);
    end
  endtask

  task automatic test_settle0_registered();
    reset = 1'b1;
    repeat (2) @(posedge CK);
    #1;
    reset = 1'b0;
    run_check("reg_settle0", 1, 2, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if (response_vec_w[1] !== 8'h2C) begin
      n_fail++;
      $display("FAIL reg_settle0 lagged table: %h required 2c", response_vec_w[1]);
    end
  endtask

  initial begin
    reset      = 1'b1;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    mode_s[0]  = 0;
    mode_s[1]  = 0;
    test_reset();
    test_and3();
    test_zero_seed_ffff();
    test_zero_seed_0000();
    test_restart_ignored();
    test_abort();
    test_settle0_registered();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
